// File: rtl/dcache_port_arbiter.sv
// ============================================================================
// Module   : dcache_port_arbiter
// Function : Round-robin sharing of the single dcache port between the load
//            (m0) and store (m1) paths; one transaction outstanding at a time.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    m0_req_valid,
  output logic                    m0_req_ready,
  input  logic [ADDR_WIDTH-1:0]   m0_req_addr,
  input  logic                    m0_req_we,
  input  logic [DATA_WIDTH-1:0]   m0_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_req_wstrb,
  output logic                    m0_resp_valid,
  input  logic                    m0_resp_ready,
  output logic [DATA_WIDTH-1:0]   m0_resp_rdata,

  input  logic                    m1_req_valid,
  output logic                    m1_req_ready,
  input  logic [ADDR_WIDTH-1:0]   m1_req_addr,
  input  logic                    m1_req_we,
  input  logic [DATA_WIDTH-1:0]   m1_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_req_wstrb,
  output logic                    m1_resp_valid,
  input  logic                    m1_resp_ready,
  output logic [DATA_WIDTH-1:0]   m1_resp_rdata,

  output logic                    c_req_valid,
  input  logic                    c_req_ready,
  output logic [ADDR_WIDTH-1:0]   c_req_addr,
  output logic                    c_req_we,
  output logic [DATA_WIDTH-1:0]   c_req_wdata,
  output logic [DATA_WIDTH/8-1:0] c_req_wstrb,
  input  logic                    c_resp_valid,
  output logic                    c_resp_ready,
  input  logic [DATA_WIDTH-1:0]   c_resp_rdata,

  output logic [1:0]              grant,
  output logic                    busy
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_ptr;
  logic [1:0]            r_grant;
  logic                  r_busy;
  logic                  r_c_req_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;

  logic w_idle;
  logic w_wait;
  logic w_win0;
  logic w_win1;
  logic w_accept;
  logic w_own0;
  logic w_own1;
  logic w_done;

  assign w_idle   = (r_state == IDLE);
  assign w_wait   = (r_state == WAIT);

  // On contention the pointer decides; a lone requester always wins.
  assign w_win0   = m0_req_valid & (~m1_req_valid | ~r_ptr);
  assign w_win1   = m1_req_valid & (~m0_req_valid |  r_ptr);
  assign w_accept = w_idle & (m0_req_valid | m1_req_valid);

  assign m0_req_ready = w_idle & w_win0;
  assign m1_req_ready = w_idle & w_win1;

  assign w_own0 = w_wait & r_grant[0];
  assign w_own1 = w_wait & r_grant[1];

  assign c_resp_ready  = (w_own0 & m0_resp_ready) | (w_own1 & m1_resp_ready);
  assign m0_resp_valid = w_own0 & c_resp_valid;
  assign m1_resp_valid = w_own1 & c_resp_valid;
  assign m0_resp_rdata = w_own0 ? c_resp_rdata : '0;
  assign m1_resp_rdata = w_own1 ? c_resp_rdata : '0;

  assign w_done = w_wait & c_resp_valid & c_resp_ready;

  assign c_req_valid = r_c_req_valid;
  assign c_req_addr  = r_addr;
  assign c_req_we    = r_we;
  assign c_req_wdata = r_wdata;
  assign c_req_wstrb = r_wstrb;
  assign grant       = r_grant;
  assign busy        = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_ptr         <= 1'b0;
      r_grant       <= 2'b00;
      r_busy        <= 1'b0;
      r_c_req_valid <= 1'b0;
      r_addr        <= '0;
      r_we          <= 1'b0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state       <= ISSUE;
            r_grant       <= {w_win1, w_win0};
            r_busy        <= 1'b1;
            r_c_req_valid <= 1'b1;
            r_addr        <= w_win1 ? m1_req_addr  : m0_req_addr;
            r_we          <= w_win1 ? m1_req_we    : m0_req_we;
            r_wdata       <= w_win1 ? m1_req_wdata : m0_req_wdata;
            r_wstrb       <= w_win1 ? m1_req_wstrb : m0_req_wstrb;
          end
        end
        ISSUE: begin
          if (c_req_ready) begin
            r_state       <= WAIT;
            r_c_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          // Hand priority to whichever requester did not own this transaction.
          if (w_done) begin
            r_state <= IDLE;
            r_grant <= 2'b00;
            r_busy  <= 1'b0;
            r_ptr   <= r_grant[0];
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
